crypt_sequencer: RTL and testbench

Round sequencer for the encrypt/decrypt datapath. It takes its mode, direction and round count from the 32-bit configuration register output. It accepts one input block per valid/ready handshake, steps the datapath through its rounds in forward or reverse order, and presents completion through an output valid/ready handshake. It also drives `cfg_lock`, which the top level ANDs (inverted) into the configuration register write enable so configuration cannot change while a block is in flight.

---
 rtl/crypt_sequencer_if.sv | 36 +++
 rtl/crypt_sequencer.sv | 117 +++++++++++
 tb/tb_crypt_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/crypt_sequencer_if.sv
// Handshake and datapath-control bundle between the round sequencer and its environment.
// The master side is the sequencer; the slave side is the block source/sink and datapath.
interface crypt_sequencer_if #(
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          dp_load;
    logic          dp_round_en;
    logic [RW-1:0] dp_round_idx;
    logic          dp_decrypt;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output dp_load,
        output dp_round_en,
        output dp_round_idx,
        output dp_decrypt
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  dp_load,
        input  dp_round_en,
        input  dp_round_idx,
        input  dp_decrypt
    );
endinterface

// File: rtl/crypt_sequencer.sv
// Round sequencer: accepts a block, steps the datapath through nr+1 rounds in forward or
// reverse key order, then holds the result until the consumer takes it.
module crypt_sequencer #(
    parameter int RW = 4,
    parameter int CW = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cfg_i,
    crypt_sequencer_if.master    bus,
    output logic                 cfg_lock_o,
    output logic [CW-1:0]        blk_count_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [RW-1:0] RCNT_ONE = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] BLK_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] nr_q;
    logic          dir_q;
    logic [CW-1:0] blk_count_q;
    logic          round_en_q;
    logic [RW-1:0] round_idx_q;
    logic          out_valid_q;
    logic          lock_q;

    logic          in_ready;
    logic          accept;
    logic          unused_cfg;

    // Bits of the configuration word outside the run/dir/rounds fields have no effect.
    assign unused_cfg = ^cfg_i[31:RW+2];

    // Input acceptance: only in IDLE, only in run mode, never while reset is asserted.
    always_comb begin
        in_ready = 1'b0;
        if (!rst_i && (state_q == IDLE)) begin
            in_ready = cfg_i[0];
        end else begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_ready & bus.in_valid;

    // Sequencer FSM; every datapath-facing output is a flop set for the upcoming state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rcnt_q      <= '0;
            nr_q        <= '0;
            dir_q       <= 1'b0;
            blk_count_q <= '0;
            round_en_q  <= 1'b0;
            round_idx_q <= '0;
            out_valid_q <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= RUN;
                        nr_q        <= cfg_i[RW+1:2];
                        dir_q       <= cfg_i[1];
                        rcnt_q      <= '0;
                        round_en_q  <= 1'b1;
                        round_idx_q <= cfg_i[1] ? cfg_i[RW+1:2] : '0;
                        lock_q      <= 1'b1;
                    end
                end
                RUN: begin
                    // Compare before incrementing so nr = 2^RW-1 never wraps rcnt.
                    if (rcnt_q == nr_q) begin
                        state_q     <= HOLD;
                        round_en_q  <= 1'b0;
                        round_idx_q <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        rcnt_q      <= rcnt_q + RCNT_ONE;
                        round_idx_q <= dir_q ? (nr_q - rcnt_q - RCNT_ONE) : (rcnt_q + RCNT_ONE);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        lock_q      <= 1'b0;
                        blk_count_q <= blk_count_q + BLK_ONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rcnt_q      <= '0;
                    round_en_q  <= 1'b0;
                    round_idx_q <= '0;
                    out_valid_q <= 1'b0;
                    lock_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.dp_load      = accept;
    assign bus.dp_round_en  = round_en_q;
    assign bus.dp_round_idx = round_idx_q;
    assign bus.dp_decrypt   = dir_q;
    assign bus.out_valid    = out_valid_q;
    assign cfg_lock_o       = lock_q;
    assign blk_count_o      = blk_count_q;
endmodule

// File: tb/tb_crypt_sequencer.sv
// Self-checking bench for crypt_sequencer: directed vector table, reset/config corner
// sequences, and randomized blocks compared against a round-list reference model.
module tb_crypt_sequencer;
    localparam int RW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cfg;
    logic          cfg_lock;
    logic [CW-1:0] blk_count;

    int passed = 0;
    int total  = 0;
    int model_cnt = 0;

    crypt_sequencer_if #(.RW(RW)) bus ();

    crypt_sequencer #(.RW(RW), .CW(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_i       (cfg),
        .bus         (bus),
        .cfg_lock_o  (cfg_lock),
        .blk_count_o (blk_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cfg;
        int          rounds;
        logic        dec;
        int          hold;
        logic [31:0] cfg_mid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // {round_en, idx[3:0], decrypt, lock, out_valid, in_ready, dp_load}
    function automatic logic [31:0] obs();
        return {22'd0, bus.dp_round_en, bus.dp_round_idx, bus.dp_decrypt, cfg_lock,
                bus.out_valid, bus.in_ready, bus.dp_load};
    endfunction

    function automatic logic [31:0] exp_word(input logic en, input logic [RW-1:0] idx,
                                             input logic dec, input logic lock,
                                             input logic ov, input logic ir);
        return {22'd0, en, idx, dec, lock, ov, ir, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete block: handshake, rounds, hold with backpressure, output handshake.
    task automatic run_block(input logic [31:0] c, input int rounds, input logic dec,
                             input int hold, input logic [31:0] c_mid);
        logic [RW-1:0] idx;
        cfg = c;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("accept", {30'd0, bus.in_ready, bus.dp_load}, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        cfg = c_mid;
        for (int k = 0; k < rounds; k++) begin
            idx = dec ? RW'(rounds - 1 - k) : RW'(k);
            @(negedge clk);
            chk("round", obs(), exp_word(1'b1, idx, dec, 1'b1, 1'b0, 1'b0));
            tick();
        end
        for (int h = 0; h <= hold; h++) begin
            bus.out_ready = (h == hold);
            @(negedge clk);
            chk("hold", obs(), exp_word(1'b0, '0, dec, 1'b1, 1'b1, 1'b0));
            chk("hold_count", 32'(blk_count), 32'(model_cnt % (1 << CW)));
            tick();
        end
        bus.out_ready = 1'b0;
        model_cnt++;
        @(negedge clk);
        chk("done", obs(), exp_word(1'b0, '0, dec, 1'b0, 1'b0, c_mid[0]));
        chk("count", 32'(blk_count), 32'(model_cnt % (1 << CW)));
    endtask

    vec_t vecs[8];

    initial begin
        int          nr;
        logic        dir;
        logic [31:0] c;
        logic        saw_ov;

        vecs[0] = '{32'h0000_000D,  4, 1'b0,  0, 32'h0000_000D};
        vecs[1] = '{32'h0000_000F,  4, 1'b1,  0, 32'h0000_000F};
        vecs[2] = '{32'h0000_000D,  4, 1'b0, 10, 32'h0000_000D};
        vecs[3] = '{32'h0000_0001,  1, 1'b0,  0, 32'h0000_0001};
        vecs[4] = '{32'h0000_0003,  1, 1'b1,  0, 32'h0000_0003};
        vecs[5] = '{32'h0000_003D, 16, 1'b0,  0, 32'h0000_003D};
        vecs[6] = '{32'h0000_003F, 16, 1'b1,  1, 32'h0000_003F};
        vecs[7] = '{32'h0000_000D,  4, 1'b0,  2, 32'h0000_0000};

        rst = 1'b1;
        cfg = 32'h0000_000D;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_held", obs(), 32'd0);
        chk("reset_count", 32'(blk_count), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release", obs(), exp_word(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1));

        // Config mode: valid held, nothing accepted.
        tick();
        cfg = 32'h0000_000C;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cfg_mode", obs(), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_block(vecs[v].cfg, vecs[v].rounds, vecs[v].dec, vecs[v].hold, vecs[v].cfg_mid);
            tick();
        end

        // Reset mid-RUN abandons the block.
        cfg = 32'h0000_003D;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run_inready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("rst_run_out", obs(), exp_word(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("rst_run_count", 32'(blk_count), 32'd0);
        saw_ov = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) saw_ov = 1'b1;
        end
        chk("rst_no_ov", {31'd0, saw_ov}, 32'd0);

        // Recovery block then random blocks: 16 in total since reset, so the count wraps.
        run_block(32'h0000_000D, 4, 1'b0, 0, 32'h0000_000D);
        for (int b = 0; b < 15; b++) begin
            tick();
            nr  = int'($urandom_range(0, (1 << RW) - 1));
            dir = 1'($urandom_range(0, 1));
            c   = ($urandom & 32'hFFFF_FFC0) | (32'(nr) << 2) | (32'(dir) << 1) | 32'd1;
            run_block(c, nr + 1, dir, int'($urandom_range(0, 3)), $urandom);
        end
        chk("wrap", 32'(blk_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
